switch_event_reader: RTL
========================

# switch_event_reader

Input-side companion to the LED/seven-segment output logic. Samples the eight raw input switches, synchronizes and debounces each bit against a shared sample tick, and turns every debounced level change into an event. Events are delivered one at a time over a valid/ready handshake, lowest switch index first. It is the reader for the user inputs, just as the LED chaser is the writer for the outputs.

## Interface
- `TICK_COUNT`, default 24'd10_000: sample-tick period in clk cycles (1 ms at 10 MHz); legal range 2..2^24-1.
- `DEBOUNCE_SAMPLES`, default 4: consecutive mismatching ticks required to accept a new level; legal range 2..15.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sw_in`  in  8: raw, asynchronous switch levels.
- `ev_ready`  in  1: consumer accepts the event this cycle.
- `lost_clr`  in  1: single-cycle clear of `lost`.
- `ev_valid`  out  1: an event is presented.
- `ev_index`  out  3: switch number of the event.
- `ev_level`  out  1: new debounced level of that switch.
- `sw_state`  out  8: current debounced levels.
- `lost`  out  1: sticky flag; at least one change was coalesced.

## Operation
- **Synchronizer.** Two flops per bit, `sw_in` to `sync2`. Reset value is 0.
- **Prescaler.** 24-bit counter counts 0..TICK_COUNT-1, then wraps to 0.
  - `tick` is high for the one cycle in which the counter equals TICK_COUNT-1.
  - Reset sets the counter to 0.
- **Debouncer, per bit i.** 4-bit `cnt[i]`; only evaluated when `tick` is high.
  - `sync2[i] == sw_state[i]`: `cnt[i]` <= 0.
  - Mismatch and `cnt[i] == DEBOUNCE_SAMPLES-1`: `sw_state[i]` <= `sync2[i]`, `cnt[i]` <= 0, raise change[i].
  - Mismatch otherwise: `cnt[i]` increments.
  - Net effect: a new level is accepted on the DEBOUNCE_SAMPLES-th consecutive mismatching tick.
- **Pending register, 8 bits.** change[i] sets `pending[i]`.
  - If change[i] arrives while `pending[i]` is already 1, set `lost` and keep `pending[i]` = 1. The bit now reflects a coalesced change.
  - If a set and a load-clear hit the same bit in the same cycle, the set wins and `lost` is not set.
- **Output stage.** Loads when `!ev_valid || ev_ready`.
  - If any `pending` bit is 1: pick the lowest index i, then `ev_index` <= i, `ev_level` <= `sw_state[i]`, `ev_valid` <= 1, clear `pending[i]`.
  - If no `pending` bit is 1: `ev_valid` <= 0.
  - While `ev_valid && !ev_ready`, `ev_index` and `ev_level` hold stable.
- **`lost` flag.** Cleared by `lost_clr` or `reset`. If `lost_clr` and a new lost condition occur in the same cycle, set wins.
- **Reset values.** `sync2`, `cnt`, prescaler, `pending`, `sw_state`, `ev_valid`, `ev_index`, `ev_level` and `lost` are all 0.
  - Switches held high through reset therefore produce level-1 events after debounce.
- **Reset mid-operation.** Any presented event is dropped and in-progress debounce counts are discarded. The next cycle behaves exactly as after power-up reset.

## Timing
- Input to `sync2`: 2 cycles.
- `sync2` change to `sw_state` change: DEBOUNCE_SAMPLES ticks.
  - Latency from the first mismatching tick is (DEBOUNCE_SAMPLES-1)·TICK_COUNT cycles, plus alignment to that first tick.
- `sw_state` / `pending` update on edge E; `ev_valid` is first high after edge E+1, when the output stage is free.
- Throughput: one event per cycle while `ev_ready` is held high.
- Handshake: a transfer occurs on an edge where `ev_valid && ev_ready`. The next pending event may appear on that same edge, with no bubble.
- `ev_ready` may be asserted before `ev_valid`; there is no combinational path from `ev_ready` to `ev_valid`.

## Test plan
Bench parameters: TICK_COUNT=4, DEBOUNCE_SAMPLES=3.

1. **Reset values.** Assert reset for 3 cycles with `sw_in`=8'hFF, then release. Required: all outputs 0 during and after reset; after 3 ticks, `sw_state`=8'hFF; events 0..7 delivered in order, each with `ev_level`=1.
2. **Clean press.** With `ev_ready`=1, hold `sw_in[2]`=1. Required: `sw_state[2]`=1 on the 3rd mismatching tick; one cycle later `ev_valid`=1 with `ev_index`=2, `ev_level`=1; `ev_valid` falls after one cycle.
3. **Bounce rejection.** Pulse `sw_in[4]` high for 6 cycles (< 3 ticks) three times, separated by 8 low cycles. Required: `sw_state[4]` stays 0, no event, `lost`=0.
4. **Priority and stall.** Bits 5 and 1 change on the same tick with `ev_ready`=0. Required: `ev_index`=1 is held stable for 10 cycles; after one ready cycle, `ev_index`=5 follows on the next cycle.
5. **Coalesce / lost.** With `ev_ready`=0 and event 1 presented, press then debounce-release switch 0. Required: `lost`=1; after ready, exactly one event with index 0, level 0. Then pulse `lost_clr`: `lost`=0.
6. **Reset mid-operation.** Assert reset while `ev_valid`=1 and `cnt[3]`=2. Required: `ev_valid`=0 next cycle; with `sw_in[3]` still held high, a full 3 ticks are again required before index-3 reports.

Source files
------------

// File: rtl/switch_event_reader.sv
// Synchronizes and debounces eight raw switches against a shared sample tick.
// Each accepted level change is queued as an event and delivered lowest index first over valid/ready.
module switch_event_reader #(
  parameter logic [23:0] TICK_COUNT       = 24'd10_000,
  parameter int          DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw_in,
  input  logic       ev_ready,
  input  logic       lost_clr,
  output logic       ev_valid,
  output logic [2:0] ev_index,
  output logic       ev_level,
  output logic [7:0] sw_state,
  output logic       lost
);

  localparam logic [23:0] TICK_LAST = TICK_COUNT - 24'd1;
  localparam logic [3:0]  CNT_LAST  = 4'(DEBOUNCE_SAMPLES - 1);

  logic [7:0]      sync1, sync2;
  logic [23:0]     presc;
  logic            tick;
  logic [7:0][3:0] cnt, cnt_next;
  logic [7:0]      state_next;
  logic [7:0]      change;
  logic [7:0]      pending, pending_next;
  logic            pick_any;
  logic [2:0]      pick_idx;
  logic            load;
  logic [7:0]      load_clr;
  logic            lost_set;

  assign tick = (presc == TICK_LAST);

  // Debounce: a bit flips only after DEBOUNCE_SAMPLES consecutive mismatching ticks.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_next   = cnt;
    state_next = sw_state;
    change     = '0;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == sw_state[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          state_next[i] = sync2[i];
          cnt_next[i]   = '0;
          change[i]     = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Lowest pending index wins: scanning downward lets the smallest index overwrite last.
  always_comb begin
    pick_any = |pending;
    pick_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) pick_idx = 3'(i);
    end
  end

  assign load         = !ev_valid || ev_ready;
  assign load_clr     = (load && pick_any) ? (8'b1 << pick_idx) : 8'b0;
  // A change landing on a bit being loaded out this cycle re-arms it without loss.
  assign lost_set     = |(change & pending & ~load_clr);
  assign pending_next = (pending & ~load_clr) | change;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the debounce counters are a handful of flops, not a RAM, so they are reset with everything else.
      sync1    <= '0;
      sync2    <= '0;
      presc    <= '0;
      cnt      <= '0;
      sw_state <= '0;
      pending  <= '0;
      ev_valid <= 1'b0;
      ev_index <= '0;
      ev_level <= 1'b0;
      lost     <= 1'b0;
    end else begin
      sync1    <= sw_in;
      sync2    <= sync1;
      presc    <= tick ? 24'd0 : presc + 24'd1;
      cnt      <= cnt_next;
      sw_state <= state_next;
      pending  <= pending_next;
      if (load) begin
        ev_valid <= pick_any;
        if (pick_any) begin
          ev_index <= pick_idx;
          ev_level <= sw_state[pick_idx];
        end
      end
      if (lost_set)      lost <= 1'b1;
      else if (lost_clr) lost <= 1'b0;
    end
  end

endmodule
